// File: rtl/seg7_scan_engine.sv
// Binary-to-display engine: hex/BCD conversion with atomic commit, then N-digit anode scanning.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
//
// state  | meaning
// IDLE   | waiting for load; display register holds last committed digits
// CONV   | double-dabble, one value bit per cycle for DATA_W cycles
// COMMIT | copy result into display register, update overflow, pulse done
module seg7_scan_engine #(
  parameter int N_DIGITS    = 8,
  parameter int DATA_W      = 32,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                CLK100MHZ,
  input  logic                CPU_RESETN,
  input  logic [DATA_W-1:0]   value,
  input  logic                load,
  input  logic                dec_mode,
  input  logic                en,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] AN
);

  localparam int BW = 4 * N_DIGITS;
  localparam int WW = (DATA_W > BW) ? DATA_W : BW;
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t              state, state_d;
  logic [DATA_W-1:0]   shreg, shreg_d;
  logic [BW-1:0]       bcd, bcd_d, bcd_adj;
  logic                conv_ovf, conv_ovf_d;
  logic                dec_q, dec_q_d;
  logic [CW-1:0]       cnt, cnt_d;
  logic [BW-1:0]       disp, disp_d;
  logic                ovf_d;
  logic [PW-1:0]       pre, pre_d;
  logic [IW-1:0]       idx, idx_d;
  logic                busy_d;
  logic                done_d;
  logic [6:0]          seg_d;
  logic [N_DIGITS-1:0] an_d;
  logic [WW-1:0]       val_ext;
  logic [N_DIGITS-1:0] blank;
  logic [3:0]          dig;
  logic                lit;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  always_comb begin
    logic [3:0] nib;
    bcd_adj = bcd;
    for (int i = 0; i < N_DIGITS; i++) begin
      nib = bcd[4*i +: 4];
      bcd_adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  end

  assign val_ext = WW'(shreg);

  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    bcd_d      = bcd;
    conv_ovf_d = conv_ovf;
    dec_q_d    = dec_q;
    cnt_d      = cnt;
    disp_d     = disp;
    ovf_d      = overflow;
    done_d     = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          shreg_d    = value;
          dec_q_d    = dec_mode;
          bcd_d      = '0;
          conv_ovf_d = 1'b0;
          cnt_d      = CW'(DATA_W - 1);
          state_d    = dec_mode ? CONV : COMMIT;
        end
      end
      CONV: begin
        // Bit leaving the top nibble means the value needs more digits than we have.
        conv_ovf_d = conv_ovf | bcd_adj[BW-1];
        bcd_d      = {bcd_adj[BW-2:0], shreg[DATA_W-1]};
        shreg_d    = shreg << 1;
        if (cnt == '0) state_d = COMMIT;
        else           cnt_d   = cnt - 1'b1;
      end
      COMMIT: begin
        if (dec_q) begin
          disp_d = bcd;
          ovf_d  = conv_ovf;
        end else begin
          disp_d = val_ext[BW-1:0];
          ovf_d  = |(val_ext >> BW);
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Outputs are registered from next-state values so new digits appear together with done.
  always_comb begin
    pre_d = pre + 1'b1;
    idx_d = idx;
    if (pre == PW'(REFRESH_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    for (int i = 0; i < N_DIGITS; i++)
      blank[i] = (i != 0) && !ovf_d && ((disp_d >> (4*i)) == '0);
`else
    blank = '0;
`endif

    dig   = disp_d[{idx_d, 2'b00} +: 4];
    lit   = en && !blank[idx_d];
    an_d  = '1;
    seg_d = 7'h7F;
    if (lit) begin
      an_d[idx_d] = 1'b0;
      seg_d       = ovf_d ? 7'h3F : glyph(dig);
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state    <= IDLE;
      shreg    <= '0;
      bcd      <= '0;
      conv_ovf <= 1'b0;
      dec_q    <= 1'b0;
      cnt      <= '0;
      disp     <= '0;
      pre      <= '0;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      seg      <= 7'h7F;
      AN       <= '1;
    end else begin
      state    <= state_d;
      shreg    <= shreg_d;
      bcd      <= bcd_d;
      conv_ovf <= conv_ovf_d;
      dec_q    <= dec_q_d;
      cnt      <= cnt_d;
      disp     <= disp_d;
      pre      <= pre_d;
      idx      <= idx_d;
      busy     <= busy_d;
      done     <= done_d;
      overflow <= ovf_d;
      seg      <= seg_d;
      AN       <= an_d;
    end
  end

endmodule
